ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the forwarded operands, funct3, rd and valid of the instruction held in ID/EX and produces a 32-bit result for the EX/MEM register. While an operation is in flight it raises a stall, which the hazard logic uses to deassert the IF/ID and ID/EX enables and to bubble EX/MEM. It covers all eight M-extension ops, including the RISC-V divide-by-zero and overflow results.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports (one clock; reset is asynchronous and active-low):
- clk_MDU  in  1  pipeline clock, rising edge.
- rst_n_MDU  in  1  async active-low reset.
- start_MDU  in  1  ID/EX holds a valid M-instruction (valid_out & is_muldiv).
- flush_MDU  in  1  kill the in-flight op; highest priority after reset.
- funct3_MDU  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Rs1_in_MDU  in  32  forwarded operand A.
- Rs2_in_MDU  in  32  forwarded operand B.
- Rd_addr_in_MDU  in  5  destination register.
- stall_out_MDU  out  1  hold IF/ID and ID/EX, bubble EX/MEM.
- done_out_MDU  out  1  one-cycle pulse: result valid this cycle.
- result_out_MDU  out  32  operation result.
- Rd_addr_out_MDU  out  5  latched rd.
- RegWrite_out_MDU  out  1  equals done_out_MDU; asserted only when rd != 0.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, start=1:
  - Latch funct3 and rd.
  - Latch the absolute values of the operands and the result sign. Signedness: MULH A and B signed; MULHSU A signed, B unsigned; MULHU and DIVU/REMU unsigned; DIV/REM signed.
  - Zero the counter.
  - Go to DIV for funct3[2]=1, otherwise MUL.
- Special divides go IDLE→DONE directly, with no iteration:
  - B==0: quotient 0xFFFFFFFF; remainder = A.
  - DIV/REM with A=0x80000000 and B=0xFFFFFFFF: quotient 0x80000000; remainder 0.
- MUL state: radix-2 shift-add into a 64-bit product register, one bit per cycle. After 32 iterations (counter wraps 31→0), negate if needed and go to DONE.
  - Result selection: MUL takes bits [31:0]; the others take bits [63:32].
- DIV state: restoring division, one quotient bit per cycle, 33-bit partial remainder. After 32 iterations, fix signs and go to DONE.
  - Sign rules: quotient sign = signA XOR signB; remainder sign = signA.
- DONE: drive done_out_MDU=1 and present the result. Always go to IDLE next cycle. start is ignored in DONE, so the same ID/EX instruction is not reissued.
- result_out_MDU and Rd_addr_out_MDU hold their values until the next entry to DONE.
- flush_MDU=1 in any state: next state IDLE, no done pulse, result register unchanged.

## Timing
- Reset (async, while rst_n_MDU=0): state IDLE, counter 0, stall_out 0, done_out 0, result_out 0, Rd_addr_out 0, RegWrite_out 0. Asserting reset mid-operation aborts the op immediately.
- stall_out_MDU is combinational and asserts when any of these hold:
  - state==IDLE & start & !flush;
  - state==MUL;
  - state==DIV.
- stall_out_MDU is low in DONE, so ID/EX and EX/MEM advance on the DONE clock edge and EX/MEM captures the result.
- Iterative op:
  - start seen at cycle 0.
  - Iterations run in cycles 1–32.
  - done at cycle 33.
  - stall high in cycles 0–32 (33 cycles).
- Special divide: stall high in cycle 0 only, done in cycle 1.
- Back-to-back ops: the next start is accepted in the IDLE cycle after DONE (cycle 34).
- flush together with start in IDLE: stall stays low and nothing is latched.

## Configuration
- MDU_FAST_MUL_EN defined:
  - All four multiplies use a single-cycle combinational 33×33 signed multiplier and go IDLE→DONE.
  - stall is high for 1 cycle, done at cycle 1.
  - The MUL state is unreachable.
- MDU_FAST_MUL_EN undefined: iterative 32-cycle multiply as above. Divides are iterative in both builds.

## Test plan
- MUL, A=7, B=0xFFFFFFFD (−3): stall high cycles 0–32, done at cycle 33, result 0xFFFFFFEB, RegWrite 1 for rd=5.
- MULHU, A=B=0xFFFFFFFF: result 0xFFFFFFFE. MULHSU, A=0xFFFFFFFF, B=2: result 0xFFFFFFFF.
- DIV −7/2: result 0xFFFFFFFD. REM −7%2: result 0xFFFFFFFF. DIVU 100/7: result 14. REMU 100%7: result 2.
- DIVU 5/0: done at cycle 1, result 0xFFFFFFFF. REMU 5%0: result 5. DIV 0x80000000/0xFFFFFFFF: result 0x80000000. REM of the same operands: result 0.
- rst_n_MDU low at iteration 10: stall, done and result immediately 0. After release, a new MUL 3*4 gives 12 at cycle 33.
- flush at iteration 20: no done pulse, stall low next cycle, result holds its previous value.
- rd=0: done pulses, RegWrite_out_MDU stays 0.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle for the EX-stage multiply/divide unit: ID/EX operands in,
// stall/done/result back to the hazard logic and EX/MEM register.
interface ex_muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start_MDU;
   logic            flush_MDU;
   logic [2:0]      funct3_MDU;
   logic [XLEN-1:0] Rs1_in_MDU;
   logic [XLEN-1:0] Rs2_in_MDU;
   logic [4:0]      Rd_addr_in_MDU;
   logic            stall_out_MDU;
   logic            done_out_MDU;
   logic [XLEN-1:0] result_out_MDU;
   logic [4:0]      Rd_addr_out_MDU;
   logic            RegWrite_out_MDU;

   modport master (
      output start_MDU, flush_MDU, funct3_MDU, Rs1_in_MDU, Rs2_in_MDU, Rd_addr_in_MDU,
      input  stall_out_MDU, done_out_MDU, result_out_MDU, Rd_addr_out_MDU, RegWrite_out_MDU
   );

   modport slave (
      input  start_MDU, flush_MDU, funct3_MDU, Rs1_in_MDU, Rs2_in_MDU, Rd_addr_in_MDU,
      output stall_out_MDU, done_out_MDU, result_out_MDU, Rd_addr_out_MDU, RegWrite_out_MDU
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a one-cycle multiplier.
module ex_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input logic             clk_MDU,
   input logic             rst_n_MDU,
   ex_muldiv_unit_if.slave mdu
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [2:0]          funct3_reg, funct3_next;
   logic [4:0]          rd_reg, rd_next;
   logic [XLEN-1:0]     opd_reg, opd_next;
   logic [2*XLEN-1:0]   prod_reg, prod_next;
   logic [XLEN-1:0]     rem_reg, rem_next;
   logic [XLEN-1:0]     quo_reg, quo_next;
   logic                neg_q_reg, neg_q_next;
   logic                neg_r_reg, neg_r_next;
   logic [XLEN-1:0]     result_reg, result_next;
   logic [4:0]          rd_out_reg, rd_out_next;

   logic [2:0]          f3;
   logic [XLEN-1:0]     rs1, rs2;
   logic                sign_a_en, sign_b_en, sa, sb;
   logic [XLEN-1:0]     abs_a, abs_b;
   logic                div_by_zero, div_ovf;
   logic [XLEN-1:0]     special_res;
   logic [XLEN:0]       mul_sum;
   logic [XLEN:0]       div_shift;
   logic                div_ge;
   logic [2*XLEN-1:0]   res_full;
   logic [XLEN-1:0]     q_fix, r_fix;

   assign f3  = mdu.funct3_MDU;
   assign rs1 = mdu.Rs1_in_MDU;
   assign rs2 = mdu.Rs2_in_MDU;

   // A is signed for MULH, MULHSU, DIV, REM; B is signed for MULH, DIV, REM
   assign sign_a_en = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
   assign sign_b_en = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
   assign sa        = sign_a_en & rs1[XLEN-1];
   assign sb        = sign_b_en & rs2[XLEN-1];
   assign abs_a     = sa ? -rs1 : rs1;
   assign abs_b     = sb ? -rs2 : rs2;

   assign div_by_zero = (rs2 == '0);
   assign div_ovf     = !f3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
   assign special_res = f3[1] ? (div_by_zero ? rs1 : '0)
                              : (div_by_zero ? '1 : 32'h8000_0000);

`ifdef MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
   assign fast_a    = {{XLEN{sa}}, rs1};
   assign fast_b    = {{XLEN{sb}}, rs2};
   assign fast_prod = fast_a * fast_b;
`endif

   always_ff @(posedge clk_MDU or negedge rst_n_MDU) begin
      if (!rst_n_MDU) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         funct3_reg <= '0;
         rd_reg     <= '0;
         opd_reg    <= '0;
         prod_reg   <= '0;
         rem_reg    <= '0;
         quo_reg    <= '0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         result_reg <= '0;
         rd_out_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         funct3_reg <= funct3_next;
         rd_reg     <= rd_next;
         opd_reg    <= opd_next;
         prod_reg   <= prod_next;
         rem_reg    <= rem_next;
         quo_reg    <= quo_next;
         neg_q_reg  <= neg_q_next;
         neg_r_reg  <= neg_r_next;
         result_reg <= result_next;
         rd_out_reg <= rd_out_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      funct3_next = funct3_reg;
      rd_next     = rd_reg;
      opd_next    = opd_reg;
      prod_next   = prod_reg;
      rem_next    = rem_reg;
      quo_next    = quo_reg;
      neg_q_next  = neg_q_reg;
      neg_r_next  = neg_r_reg;
      result_next = result_reg;
      rd_out_next = rd_out_reg;
      mul_sum     = '0;
      div_shift   = '0;
      div_ge      = 1'b0;
      res_full    = '0;
      q_fix       = '0;
      r_fix       = '0;

      // A flush abandons the op and holds every datapath register
      if (mdu.flush_MDU) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (mdu.start_MDU) begin
                  funct3_next = f3;
                  rd_next     = mdu.Rd_addr_in_MDU;
                  neg_q_next  = sa ^ sb;
                  neg_r_next  = sa;
                  cnt_next    = '0;
                  if (f3[2]) begin
                     opd_next = abs_b;
                     quo_next = abs_a;
                     rem_next = '0;
                     if (div_by_zero || div_ovf) begin
                        result_next = special_res;
                        rd_out_next = mdu.Rd_addr_in_MDU;
                        state_next  = DONE;
                     end else begin
                        state_next  = DIV;
                     end
                  end else begin
`ifdef MDU_FAST_MUL_EN
                     result_next = (f3 == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
                     rd_out_next = mdu.Rd_addr_in_MDU;
                     state_next  = DONE;
`else
                     opd_next   = abs_a;
                     prod_next  = {{XLEN{1'b0}}, abs_b};
                     state_next = MUL;
`endif
                  end
               end
            end
            MUL: begin
               // Multiplier sits in the low half and shifts out as the sum shifts in
               mul_sum   = {1'b0, prod_reg[2*XLEN-1:XLEN]} + (prod_reg[0] ? {1'b0, opd_reg} : '0);
               prod_next = {mul_sum, prod_reg[XLEN-1:1]};
               cnt_next  = cnt_reg + 1'b1;
               if (cnt_reg == '1) begin
                  res_full    = neg_q_reg ? -prod_next : prod_next;
                  result_next = (funct3_reg == 3'd0) ? res_full[XLEN-1:0] : res_full[2*XLEN-1:XLEN];
                  rd_out_next = rd_reg;
                  state_next  = DONE;
               end
            end
            DIV: begin
               // 33-bit trial remainder; the kept remainder is always below the divisor
               div_shift = {rem_reg, quo_reg[XLEN-1]};
               div_ge    = (div_shift >= {1'b0, opd_reg});
               rem_next  = div_ge ? XLEN'(div_shift - {1'b0, opd_reg}) : div_shift[XLEN-1:0];
               quo_next  = {quo_reg[XLEN-2:0], div_ge};
               cnt_next  = cnt_reg + 1'b1;
               if (cnt_reg == '1) begin
                  q_fix       = neg_q_reg ? -quo_next : quo_next;
                  r_fix       = neg_r_reg ? -rem_next : rem_next;
                  result_next = funct3_reg[1] ? r_fix : q_fix;
                  rd_out_next = rd_reg;
                  state_next  = DONE;
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign mdu.stall_out_MDU    = rst_n_MDU &
                                 (((state_reg == IDLE) && mdu.start_MDU && !mdu.flush_MDU) ||
                                  (state_reg == MUL) || (state_reg == DIV));
   assign mdu.done_out_MDU     = (state_reg == DONE) && !mdu.flush_MDU;
   assign mdu.result_out_MDU   = result_reg;
   assign mdu.Rd_addr_out_MDU  = rd_out_reg;
   assign mdu.RegWrite_out_MDU = mdu.done_out_MDU && (rd_out_reg != 5'd0);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: driver pushes model results, monitor checks done pulses.
module tb_ex_muldiv_unit;
   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ex_muldiv_unit_if bus ();

   ex_muldiv_unit dut (
      .clk_MDU   (clk),
      .rst_n_MDU (rst_n),
      .mdu       (bus)
   );

   exp_t        exp_q[$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   int          stray_cnt = 0;
   logic [31:0] exp_last  = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub, q;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 64'd0;
      q   = 0;
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            q = sa / sb; return q[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            q = sa % sb; return q[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2]) begin
         if (b == 0) return 1;
         if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
         return 33;
      end
`ifdef MDU_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
   endfunction

   task automatic drive_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      bus.start_MDU      = 1'b1;
      bus.funct3_MDU     = f;
      bus.Rs1_in_MDU     = a;
      bus.Rs2_in_MDU     = b;
      bus.Rd_addr_in_MDU = rd;
   endtask

   // Issues one op, measures done latency and stall length; data is checked by the monitor
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      exp_t e;
      int   lat, stall_cnt, want;
      e.res = model(f, a, b);
      e.rd  = rd;
      want  = exp_latency(f, a, b);
      lat   = -1;
      stall_cnt = 0;
      @(negedge clk);
      exp_q.push_back(e);
      exp_last = e.res;
      drive_op(f, a, b, rd);
      for (int c = 0; c < 60; c++) begin
         if (c > 0) begin
            @(negedge clk);
            bus.start_MDU = 1'b0;
         end
         #1;
         if (bus.stall_out_MDU) stall_cnt++;
         if (bus.done_out_MDU) begin
            lat = c;
            break;
         end
      end
      check($sformatf("latency f%0d", f), lat, want);
      check($sformatf("stall cycles f%0d", f), stall_cnt, want);
      bus.start_MDU = 1'b0;
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (bus.done_out_MDU === 1'b1) begin
            $display("done: result=0x%08h rd=%0d regwrite=%0b", bus.result_out_MDU,
                     bus.Rd_addr_out_MDU, bus.RegWrite_out_MDU);
            if (exp_q.size() == 0) begin
               stray_cnt++;
            end else begin
               e = exp_q.pop_front();
               check("result", bus.result_out_MDU, e.res);
               check("rd_out", {27'd0, bus.Rd_addr_out_MDU}, {27'd0, e.rd});
               check("regwrite", {31'd0, bus.RegWrite_out_MDU}, {31'd0, (e.rd != 5'd0)});
            end
         end
      end
   end

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      rst_n              = 1'b0;
      bus.start_MDU      = 1'b0;
      bus.flush_MDU      = 1'b0;
      bus.funct3_MDU     = 3'd0;
      bus.Rs1_in_MDU     = 32'd0;
      bus.Rs2_in_MDU     = 32'd0;
      bus.Rd_addr_in_MDU = 5'd0;
      repeat (3) @(negedge clk);
      #1;
      check("reset stall", {31'd0, bus.stall_out_MDU}, 32'd0);
      check("reset done", {31'd0, bus.done_out_MDU}, 32'd0);
      check("reset result", bus.result_out_MDU, 32'd0);
      check("reset rd_out", {27'd0, bus.Rd_addr_out_MDU}, 32'd0);
      check("reset regwrite", {31'd0, bus.RegWrite_out_MDU}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd7);
      run_op(3'd1, 32'hFFFF_FFF0, 32'h0000_1000, 5'd8);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10);
      run_op(3'd5, 32'd100, 32'd7, 5'd11);
      run_op(3'd7, 32'd100, 32'd7, 5'd12);
      run_op(3'd5, 32'd5, 32'd0, 5'd13);
      run_op(3'd7, 32'd5, 32'd0, 5'd14);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
      run_op(3'd5, 32'd100, 32'd7, 5'd0);

      // Flush during iteration 20: no done, stall drops, result holds
      @(negedge clk);
      drive_op(3'd0, $urandom, $urandom, 5'd3);
      @(negedge clk);
      bus.start_MDU = 1'b0;
      repeat (19) @(negedge clk);
      bus.flush_MDU = 1'b1;
      #1;
      check("done under flush", {31'd0, bus.done_out_MDU}, 32'd0);
      @(negedge clk);
      bus.flush_MDU = 1'b0;
      #1;
      check("stall after flush", {31'd0, bus.stall_out_MDU}, 32'd0);
      check("result after flush", bus.result_out_MDU, exp_last);
      repeat (40) @(negedge clk);

      // Reset at iteration 10 aborts immediately
      drive_op(3'd4, 32'd12345, 32'd17, 5'd4);
      @(negedge clk);
      bus.start_MDU = 1'b0;
      repeat (9) @(negedge clk);
      #1;
      check("stall mid-op", {31'd0, bus.stall_out_MDU}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("stall in reset", {31'd0, bus.stall_out_MDU}, 32'd0);
      check("done in reset", {31'd0, bus.done_out_MDU}, 32'd0);
      check("result in reset", bus.result_out_MDU, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_last = 32'd0;
      run_op(3'd0, 32'd3, 32'd4, 5'd1);

      for (int i = 0; i < 25; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom;
         endcase
         run_op(f, a, b, 5'($urandom_range(0, 31)));
      end

      // Flush together with start in IDLE: nothing starts
      @(negedge clk);
      drive_op(3'd5, 32'd99, 32'd3, 5'd2);
      bus.flush_MDU = 1'b1;
      #1;
      check("stall flush+start", {31'd0, bus.stall_out_MDU}, 32'd0);
      @(negedge clk);
      bus.start_MDU = 1'b0;
      bus.flush_MDU = 1'b0;
      #1;
      check("stall after flush+start", {31'd0, bus.stall_out_MDU}, 32'd0);
      check("result after flush+start", bus.result_out_MDU, exp_last);
      repeat (40) @(negedge clk);

      check("outstanding expectations", exp_q.size(), 32'd0);
      check("stray done pulses", stray_cnt, 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
